vram_arbiter: RTL and testbench

- Two-master to one-slave arbiter for the video memory port of the video project.
- Master 0 is the display fetch path (VGA line FIFO filler). It has priority because display underrun is visible.
- Master 1 is the pixel writer (pattern/mire generator or host writes).
- Each master is bounded by a burst limit. Master 1 is protected from starvation by a wait counter.
- All ports use a Wishbone-classic-style handshake (cyc/stb/we/ack).

---
 rtl/vram_arbiter_pkg.sv | 26 ++
 rtl/vram_arbiter_if.sv | 18 +
 rtl/vram_arbiter.sv | 98 +++++++++
 tb/tb_vram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared types and defaults for the two-master video memory arbiter.
package vram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   // 0 = display fetch path, 1 = pixel writer
   typedef logic master_idx_t;

   localparam int DEF_AW        = 20;
   localparam int DEF_DW        = 16;
   localparam int DEF_MAX_BURST = 16;
   localparam int DEF_MAX_WAIT  = 4;

   function automatic logic [1:0] gnt_of(arb_state_t s);
      case (s)
         GNT0:    return 2'b01;
         GNT1:    return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Wishbone-classic-style port bundle used for both master ports and the slave port.
interface vram_arbiter_if #(
   parameter int AW = 20,
   parameter int DW = 16
);
   // Handshake: a word transfers in every cycle where cyc & stb & ack are all high;
   // cyc stays high for the whole transfer and ack is combinational from the slave.
   logic          cyc;
   logic          stb;
   logic          we;
   logic [AW-1:0] adr;
   logic [DW-1:0] dat_w;
   logic          ack;
   logic [DW-1:0] dat_r;

   modport master (output cyc, stb, we, adr, dat_w, input  ack, dat_r);
   modport slave  (input  cyc, stb, we, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/vram_arbiter.sv
// Two-master arbiter for the video memory port: display fetch has priority,
// each grant is burst-limited and the pixel writer is protected by a wait counter.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int DW        = DEF_DW,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int MAX_WAIT  = DEF_MAX_WAIT,
   localparam int BW       = $clog2(MAX_BURST + 1),
   localparam int WW       = $clog2(MAX_WAIT + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   vram_arbiter_if.slave    m0,
   vram_arbiter_if.slave    m1,
   vram_arbiter_if.master   s,
   output logic [1:0]       gnt,
   output arb_state_t       dbg_state,
   output logic [BW-1:0]    dbg_burst_cnt,
   output logic [WW-1:0]    dbg_wait_cnt
);

   arb_state_t    state_q, state_d, other_st;
   logic [BW-1:0] burst_q, burst_d, burst_acked;
   logic [WW-1:0] wait_q, wait_d;
   logic          granted;
   master_idx_t   sel;
   logic          own_cyc, oth_cyc;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         burst_q <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      granted     = (state_q != IDLE);
      sel         = (state_q == GNT1);
      own_cyc     = sel ? m1.cyc : m0.cyc;
      oth_cyc     = sel ? m0.cyc : m1.cyc;
      other_st    = sel ? GNT0 : GNT1;
      burst_acked = burst_q;
      if (granted && s.ack && (burst_q != BW'(MAX_BURST)))
         burst_acked = burst_q + 1'b1;

      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (m0.cyc && m1.cyc)
               state_d = (wait_q >= WW'(MAX_WAIT)) ? GNT1 : GNT0;
            else if (m0.cyc)
               state_d = GNT0;
            else if (m1.cyc)
               state_d = GNT1;
         end
         GNT0, GNT1: begin
            // Release wins over preemption; both hand straight to a waiting master.
            if (!own_cyc)
               state_d = oth_cyc ? other_st : IDLE;
            else if ((burst_acked == BW'(MAX_BURST)) && oth_cyc)
               state_d = other_st;
         end
         default: state_d = IDLE;
      endcase

      burst_d = (state_d != state_q) ? '0 : burst_acked;

      wait_d = wait_q;
      if ((state_d == GNT1) && (state_q != GNT1))
         wait_d = '0;
      else if ((state_d == GNT0) && (state_q != GNT0) && m1.cyc && (wait_q != WW'(MAX_WAIT)))
         wait_d = wait_q + 1'b1;
   end

   assign s.cyc   = granted & own_cyc;
   assign s.stb   = granted & (sel ? m1.stb : m0.stb);
   assign s.we    = granted & (sel ? m1.we  : m0.we);
   assign s.adr   = granted ? (sel ? m1.adr   : m0.adr)   : '0;
   assign s.dat_w = granted ? (sel ? m1.dat_w : m0.dat_w) : '0;

   assign m0.ack   = s.ack & (state_q == GNT0);
   assign m1.ack   = s.ack & (state_q == GNT1);
   assign m0.dat_r = s.dat_r;
   assign m1.dat_r = s.dat_r;

   assign gnt           = gnt_of(state_q);
   assign dbg_state     = state_q;
   assign dbg_burst_cnt = burst_q;
   assign dbg_wait_cnt  = wait_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus random traffic, every cycle's
// outputs compared against an ownership-level reference model through a queue.
module tb_vram_arbiter;
   import vram_arb_pkg::*;

   localparam int AW = 20;
   localparam int DW = 16;
   localparam int MB = 16;
   localparam int MW = 4;

   logic CLK = 1'b0;
   logic RST;
   always #10 CLK = ~CLK;

   vram_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
   vram_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();
   vram_arbiter_if #(.AW(AW), .DW(DW)) s_bus ();

   logic [1:0] gnt;
   arb_state_t dbg_state;
   logic [4:0] dbg_burst_cnt;
   logic [2:0] dbg_wait_cnt;

   vram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB), .MAX_WAIT(MW)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .m0            (m0_bus),
      .m1            (m1_bus),
      .s             (s_bus),
      .gnt           (gnt),
      .dbg_state     (dbg_state),
      .dbg_burst_cnt (dbg_burst_cnt),
      .dbg_wait_cnt  (dbg_wait_cnt)
   );

   // ---------------- stimulus drivers ----------------
   logic          m_cyc [2];
   logic          m_stb [2];
   logic          m_we  [2];
   logic [AW-1:0] m_adr [2];
   logic [DW-1:0] m_dat [2];
   logic          s_ack_drv;
   logic [DW-1:0] s_dat_drv;

   assign m0_bus.cyc = m_cyc[0]; assign m0_bus.stb = m_stb[0]; assign m0_bus.we = m_we[0];
   assign m0_bus.adr = m_adr[0]; assign m0_bus.dat_w = m_dat[0];
   assign m1_bus.cyc = m_cyc[1]; assign m1_bus.stb = m_stb[1]; assign m1_bus.we = m_we[1];
   assign m1_bus.adr = m_adr[1]; assign m1_bus.dat_w = m_dat[1];
   assign s_bus.ack   = s_ack_drv;
   assign s_bus.dat_r = s_dat_drv;

   int    vectors = 0;
   int    miscompares = 0;
   string phase = "reset";
   logic  rand_en = 1'b0;
   logic  slave_auto = 1'b0;
   int    ack_pct = 60;
   logic  ack_seen [2];
   int    left [2];
   int    gap [2];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      ack_seen[0] = m0_bus.ack;
      ack_seen[1] = m1_bus.ack;
   end

   always @(posedge CLK) begin
      #1;
      if (slave_auto) begin
         s_ack_drv = ($urandom_range(0, 99) < ack_pct);
         s_dat_drv = DW'($urandom);
      end
   end

   // Random masters: each runs transfers of random length, counting its own acks.
   always @(posedge CLK) begin
      #1;
      if (rand_en) begin
         for (int i = 0; i < 2; i++) begin
            if (m_cyc[i]) begin
               if (ack_seen[i]) begin
                  left[i]  = left[i] - 1;
                  m_adr[i] = AW'($urandom);
                  m_we[i]  = 1'($urandom);
                  m_dat[i] = DW'($urandom);
               end
               m_stb[i] = ($urandom_range(0, 3) != 0);
               if (left[i] <= 0 || $urandom_range(0, 99) < 2) begin
                  m_cyc[i] = 1'b0;
                  m_stb[i] = 1'b0;
                  gap[i]   = $urandom_range(0, 3);
               end
            end else if (gap[i] > 0) begin
               gap[i] = gap[i] - 1;
            end else begin
               m_cyc[i] = 1'b1;
               m_stb[i] = 1'b1;
               left[i]  = $urandom_range(1, 40);
               m_adr[i] = AW'($urandom);
               m_we[i]  = 1'($urandom);
               m_dat[i] = DW'($urandom);
            end
         end
      end
   end

   // ---------------- reference model ----------------
   // owner: -1 nobody, 0 or 1 the master currently holding the memory port.
   int owner = -1;
   int acks = 0;
   int losses = 0;
   int nxt;

   always @(posedge CLK) begin
      if (RST) begin
         owner = -1; acks = 0; losses = 0;
      end else begin
         if (owner >= 0 && s_ack_drv) acks = (acks < MB) ? acks + 1 : MB;
         nxt = owner;
         if (owner < 0) begin
            if (m_cyc[0] && m_cyc[1]) nxt = (losses >= MW) ? 1 : 0;
            else if (m_cyc[0])        nxt = 0;
            else if (m_cyc[1])        nxt = 1;
         end else if (!m_cyc[owner]) begin
            nxt = m_cyc[1-owner] ? 1 - owner : -1;
         end else if (acks == MB && m_cyc[1-owner]) begin
            nxt = 1 - owner;
         end
         if (nxt != owner) begin
            acks = 0;
            if (nxt == 1) losses = 0;
            else if (nxt == 0 && m_cyc[1]) losses = (losses < MW) ? losses + 1 : MW;
         end
         owner = nxt;
      end
   end

   typedef struct packed {
      logic [1:0]    gnt;
      logic          cyc, stb, we;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat_w;
      logic          ack0, ack1;
      logic [DW-1:0] dat_r;
      logic [4:0]    burst;
      logic [2:0]    waitc;
   } exp_t;

   exp_t exp_q [$];

   always @(negedge CLK) begin
      exp_t e;
      e = '0;
      if (owner >= 0) begin
         e.gnt   = (owner == 0) ? 2'b01 : 2'b10;
         e.cyc   = m_cyc[owner];
         e.stb   = m_stb[owner];
         e.we    = m_we[owner];
         e.adr   = m_adr[owner];
         e.dat_w = m_dat[owner];
         e.ack0  = s_ack_drv && (owner == 0);
         e.ack1  = s_ack_drv && (owner == 1);
      end
      e.dat_r = s_dat_drv;
      e.burst = 5'(acks);
      e.waitc = 3'(losses);
      exp_q.push_back(e);
   end

   // ---------------- monitor ----------------
   always @(negedge CLK) begin
      exp_t a, e;
      #1;
      a.gnt = gnt; a.cyc = s_bus.cyc; a.stb = s_bus.stb; a.we = s_bus.we;
      a.adr = s_bus.adr; a.dat_w = s_bus.dat_w; a.ack0 = m0_bus.ack; a.ack1 = m1_bus.ack;
      a.dat_r = m0_bus.dat_r; a.burst = dbg_burst_cnt; a.waitc = dbg_wait_cnt;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty phase=%s got=%h", phase, a);
      end else begin
         e = exp_q.pop_front();
         if (a !== e || m1_bus.dat_r !== s_dat_drv) begin
            miscompares++;
            $display("FAIL %s t=%0t got gnt=%b cyc=%b adr=%h ack=%b%b dat_r=%h burst=%0d wait=%0d exp gnt=%b cyc=%b adr=%h ack=%b%b dat_r=%h burst=%0d wait=%0d",
                     phase, $time, a.gnt, a.cyc, a.adr, a.ack1, a.ack0, a.dat_r, a.burst, a.waitc,
                     e.gnt, e.cyc, e.adr, e.ack1, e.ack0, e.dat_r, e.burst, e.waitc);
         end
      end
   end

   task automatic bound_check(input string name, input int got, input int need);
      vectors++;
      if (got < need) begin
         miscompares++;
         $display("FAIL %s timeout got=%0d acks required=%0d", name, got, need);
      end
   endtask

   task automatic set_master(input int i, input logic cyc, input logic [AW-1:0] adr, input logic we);
      m_cyc[i] = cyc; m_stb[i] = cyc; m_adr[i] = adr; m_we[i] = we;
      m_dat[i] = DW'($urandom);
   endtask

   // ---------------- directed sequence + random traffic ----------------
   initial begin
      int cnt;
      RST = 1'b1;
      for (int i = 0; i < 2; i++) begin
         m_cyc[i] = 0; m_stb[i] = 0; m_we[i] = 0; m_adr[i] = '0; m_dat[i] = '0;
         left[i] = 0; gap[i] = 0;
      end
      s_ack_drv = 1'b0; s_dat_drv = '0;

      // reset with both masters requesting and a stray slave ack
      set_master(0, 1, 20'h00100, 0);
      set_master(1, 1, 20'h00200, 1);
      s_ack_drv = 1'b1; s_dat_drv = 16'h1234;
      repeat (3) tick();
      RST = 1'b0; s_ack_drv = 1'b0;
      phase = "reset_release";
      repeat (3) tick();
      set_master(0, 0, '0, 0); set_master(1, 0, '0, 0);
      repeat (2) tick();

      // single read by the pixel writer, two wait states
      phase = "m1_read";
      set_master(1, 1, 20'h00010, 0);
      tick(); tick(); tick();
      s_ack_drv = 1'b1; s_dat_drv = 16'hBEEF;
      tick();
      s_ack_drv = 1'b0; set_master(1, 0, '0, 0);
      repeat (2) tick();

      // burst limit with continuous competition
      phase = "burst_limit";
      set_master(0, 1, 20'h0A000, 0);
      tick();
      set_master(1, 1, 20'h0B000, 1);
      ack_pct = 100; slave_auto = 1'b1;
      cnt = 0;
      for (int c = 0; c < 400 && cnt < 40; c++) begin
         tick();
         if (ack_seen[0]) begin cnt++; m_adr[0] = m_adr[0] + 1'b1; end
      end
      bound_check("burst_limit_m0_acks", cnt, 40);
      set_master(0, 0, '0, 0);
      repeat (5) tick();
      set_master(1, 0, '0, 0);
      slave_auto = 1'b0; s_ack_drv = 1'b0;
      repeat (2) tick();

      // anti-starvation: m1 loses four simultaneous arbitrations, wins the fifth
      phase = "anti_starve";
      RST = 1'b1; tick(); RST = 1'b0;
      for (int r = 0; r < 5; r++) begin
         set_master(0, 1, 20'(32'h300 + r), 1);
         set_master(1, 1, 20'(32'h400 + r), 1);
         tick();
         set_master(1, 0, '0, 0); s_ack_drv = 1'b1;
         tick();
         set_master(0, 0, '0, 0); s_ack_drv = 1'b0;
         repeat (2) tick();
      end

      // back-to-back handover on release
      phase = "handover";
      set_master(0, 1, 20'h05555, 0);
      tick();
      set_master(1, 1, 20'h0AAAA, 1);
      tick(); tick();
      set_master(0, 0, '0, 0);
      tick(); tick();
      set_master(1, 0, '0, 0);
      repeat (2) tick();

      // reset in the middle of an m0 burst
      phase = "reset_mid_burst";
      set_master(0, 1, 20'h07000, 0);
      s_ack_drv = 1'b1;
      cnt = 0;
      for (int c = 0; c < 50 && cnt < 5; c++) begin
         tick();
         if (ack_seen[0]) cnt++;
      end
      bound_check("reset_mid_burst_acks", cnt, 5);
      RST = 1'b1;
      repeat (2) tick();
      RST = 1'b0;
      set_master(1, 1, 20'h08000, 1);
      repeat (4) tick();
      set_master(0, 0, '0, 0); set_master(1, 0, '0, 0); s_ack_drv = 1'b0;
      repeat (2) tick();

      // random traffic
      phase = "random";
      ack_pct = 60; slave_auto = 1'b1; rand_en = 1'b1;
      repeat (3000) tick();
      rand_en = 1'b0; slave_auto = 1'b0;
      tick();
      set_master(0, 0, '0, 0); set_master(1, 0, '0, 0); s_ack_drv = 1'b0;
      phase = "drain";
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
